// File: rtl/robocup_cmd_decoder_if.sv
// Byte-stream handshake between the SPI slave shifter and the command decoder.
// The shifter is the master: it reports frame boundaries and received bytes, and takes back the next byte to shift out.
interface robocup_cmd_decoder_if;
    logic       frame_start;
    logic       frame_end;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_load;

    modport master (
        output frame_start, frame_end, rx_valid, rx_data,
        input  tx_data, tx_load
    );

    modport slave (
        input  frame_start, frame_end, rx_valid, rx_data,
        output tx_data, tx_load
    );
endinterface

// File: rtl/robocup_cmd_decoder.sv
// SPI command decoder for the motor board: parses command frames, issues duty/hall writes
// and streams back encoder/hall/duty snapshots, one response byte per received byte.
module robocup_cmd_decoder #(
    parameter int NUM_MOTORS = 5,
    parameter int ENC_WIDTH  = 16,
    parameter int DUTY_WIDTH = 11,
    parameter int HALL_WIDTH = 8
) (
    input  logic                             sysclk,
    input  logic                             rst,
    robocup_cmd_decoder_if.slave             spi,
    input  logic [NUM_MOTORS*ENC_WIDTH-1:0]  enc_counts,
    input  logic [NUM_MOTORS*HALL_WIDTH-1:0] hall_counts,
    input  logic [NUM_MOTORS*DUTY_WIDTH-1:0] duty_rb,
    output logic                             duty_wr,
    output logic [2:0]                       duty_wr_idx,
    output logic [DUTY_WIDTH-1:0]            duty_wr_data,
    output logic                             hall_wr,
    output logic [2:0]                       hall_wr_idx,
    output logic [HALL_WIDTH-1:0]            hall_wr_data,
    output logic                             motors_en,
    output logic                             busy
);
    localparam int NBYTES = 2 * NUM_MOTORS;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam int IW     = $clog2(NBYTES);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DROP} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [7:0]              low_q, low_d;
    logic                    pend_q, pend_d;
    logic [7:0]              resp_q [NBYTES];
    logic [7:0]              resp_d [NBYTES];
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_load_q, tx_load_d;
    logic                    duty_wr_q, duty_wr_d;
    logic [2:0]              duty_idx_q, duty_idx_d;
    logic [DUTY_WIDTH-1:0]   duty_data_q, duty_data_d;
    logic                    hall_wr_q, hall_wr_d;
    logic [2:0]              hall_idx_q, hall_idx_d;
    logic [HALL_WIDTH-1:0]   hall_data_q, hall_data_d;
    logic                    motors_en_q, motors_en_d;
    logic                    busy_q, busy_d;

    // Number of data bytes that carry meaning for a command; everything past it is dropped.
    function automatic logic [CW-1:0] payload_len(input logic [7:0] cmd);
        case (cmd)
            8'h80, 8'h93: payload_len = CW'(NBYTES);
            8'h12, 8'h92: payload_len = CW'(NUM_MOTORS);
            default:      payload_len = '0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        low_d       = low_q;
        pend_d      = 1'b0;
        resp_d      = resp_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        duty_wr_d   = 1'b0;
        duty_idx_d  = duty_idx_q;
        duty_data_d = duty_data_q;
        hall_wr_d   = 1'b0;
        hall_idx_d  = hall_idx_q;
        hall_data_d = hall_data_q;
        motors_en_d = motors_en_q;

        // Response byte goes out the cycle after the byte that requested it was registered.
        if (pend_q) begin
            tx_load_d = 1'b1;
            if (state_q == S_DATA && cnt_q < CW'(NBYTES)) begin
                tx_data_d = resp_q[cnt_q[IW-1:0]];
            end else begin
                tx_data_d = 8'h00;
            end
        end

        unique case (state_q)
            S_CMD: begin
                if (spi.rx_valid) begin
                    cmd_d  = spi.rx_data;
                    cnt_d  = '0;
                    pend_d = 1'b1;
                    for (int i = 0; i < NBYTES; i++) resp_d[i] = 8'h00;
                    for (int m = 0; m < NUM_MOTORS; m++) begin
                        case (spi.rx_data)
                            8'h80: begin
                                resp_d[2*m]   = enc_counts[m*ENC_WIDTH +: 8];
                                resp_d[2*m+1] = enc_counts[m*ENC_WIDTH+8 +: 8];
                            end
                            8'h92: resp_d[m] = 8'(hall_counts[m*HALL_WIDTH +: HALL_WIDTH]);
                            8'h93: begin
                                resp_d[2*m]   = duty_rb[m*DUTY_WIDTH +: 8];
                                resp_d[2*m+1] = 8'(duty_rb[m*DUTY_WIDTH+8 +: DUTY_WIDTH-8]);
                            end
                            default: ;
                        endcase
                    end
                    if (spi.rx_data[6:0] == 7'h30) motors_en_d = spi.rx_data[7];
                    state_d = (payload_len(spi.rx_data) == '0) ? S_DROP : S_DATA;
                end
            end
            S_DATA: begin
                if (spi.rx_valid) begin
                    pend_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cmd_q == 8'h80) begin
                        if (!cnt_q[0]) begin
                            low_d = spi.rx_data;
                        end else begin
                            duty_wr_d   = 1'b1;
                            duty_idx_d  = 3'(cnt_q >> 1);
                            duty_data_d = {spi.rx_data[DUTY_WIDTH-9:0], low_q};
                        end
                    end else if (cmd_q == 8'h12) begin
                        hall_wr_d   = 1'b1;
                        hall_idx_d  = 3'(cnt_q);
                        hall_data_d = HALL_WIDTH'(spi.rx_data);
                    end
                    if (cnt_q + 1'b1 == payload_len(cmd_q)) state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (spi.rx_valid) pend_d = 1'b1;
            end
            default: ;
        endcase

        if (spi.frame_end) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
        end

        // A new frame start wins over anything the old frame produced this cycle.
        if (spi.frame_start) begin
            state_d     = S_CMD;
            pend_d      = 1'b0;
            duty_wr_d   = 1'b0;
            hall_wr_d   = 1'b0;
            motors_en_d = motors_en_q;
            tx_data_d   = {motors_en_q, 7'h00};
            tx_load_d   = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            low_q       <= '0;
            pend_q      <= 1'b0;
            for (int i = 0; i < NBYTES; i++) resp_q[i] <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            duty_wr_q   <= 1'b0;
            duty_idx_q  <= '0;
            duty_data_q <= '0;
            hall_wr_q   <= 1'b0;
            hall_idx_q  <= '0;
            hall_data_q <= '0;
            motors_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            low_q       <= low_d;
            pend_q      <= pend_d;
            resp_q      <= resp_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            duty_wr_q   <= duty_wr_d;
            duty_idx_q  <= duty_idx_d;
            duty_data_q <= duty_data_d;
            hall_wr_q   <= hall_wr_d;
            hall_idx_q  <= hall_idx_d;
            hall_data_q <= hall_data_d;
            motors_en_q <= motors_en_d;
            busy_q      <= busy_d;
        end
    end

    assign spi.tx_data  = tx_data_q;
    assign spi.tx_load  = tx_load_q;
    assign duty_wr      = duty_wr_q;
    assign duty_wr_idx  = duty_idx_q;
    assign duty_wr_data = duty_data_q;
    assign hall_wr      = hall_wr_q;
    assign hall_wr_idx  = hall_idx_q;
    assign hall_wr_data = hall_data_q;
    assign motors_en    = motors_en_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_robocup_cmd_decoder.sv
// Bench for robocup_cmd_decoder: table of command frames plus hand-written abort/reset/edge sequences,
// with tx bytes and register writes predicted by a small model and checked from queues.
`timescale 1ns/1ps
module tb_robocup_cmd_decoder;
    localparam int NM = 5;
    localparam int EW = 16;
    localparam int DW = 11;
    localparam int HW = 8;

    logic sysclk = 1'b0;
    logic rst;
    always #5 sysclk = ~sysclk;

    robocup_cmd_decoder_if spi();

    logic [NM*EW-1:0] enc_counts;
    logic [NM*HW-1:0] hall_counts;
    logic [NM*DW-1:0] duty_rb;
    logic             duty_wr;
    logic [2:0]       duty_wr_idx;
    logic [DW-1:0]    duty_wr_data;
    logic             hall_wr;
    logic [2:0]       hall_wr_idx;
    logic [HW-1:0]    hall_wr_data;
    logic             motors_en;
    logic             busy;

    robocup_cmd_decoder #(
        .NUM_MOTORS(NM), .ENC_WIDTH(EW), .DUTY_WIDTH(DW), .HALL_WIDTH(HW)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .spi          (spi.slave),
        .enc_counts   (enc_counts),
        .hall_counts  (hall_counts),
        .duty_rb      (duty_rb),
        .duty_wr      (duty_wr),
        .duty_wr_idx  (duty_wr_idx),
        .duty_wr_data (duty_wr_data),
        .hall_wr      (hall_wr),
        .hall_wr_idx  (hall_wr_idx),
        .hall_wr_data (hall_wr_data),
        .motors_en    (motors_en),
        .busy         (busy)
    );

    typedef struct {
        logic [7:0]   cmd;
        int           n;
        logic [191:0] d;
        logic         fe;
        logic         exp_en;
        int           exp_wr;
    } vec_t;

    vec_t        tbl [9];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          wr_seen = 0;
    logic [7:0]  tx_q [$];
    logic [31:0] wr_q [$];
    logic        m_en;
    logic [7:0]  hall_mem [NM];
    logic [7:0]  exp_resp [2*NM];

    always_comb begin
        hall_counts = '0;
        for (int i = 0; i < NM; i++) hall_counts[i*HW +: HW] = hall_mem[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected no event", name, act);
    endtask

    // Scoreboard side: every DUT output event is matched against the model's queues.
    always @(negedge sysclk) begin
        if (spi.tx_load) begin
            if (tx_q.size() == 0) unexpected("tx_load", {24'h0, spi.tx_data});
            else check("tx_data", {24'h0, spi.tx_data}, {24'h0, tx_q.pop_front()});
        end
        if (duty_wr) begin
            wr_seen++;
            if (wr_q.size() == 0) unexpected("duty_wr", {8'd1, 8'(duty_wr_idx), 16'(duty_wr_data)});
            else check("duty_wr", {8'd1, 8'(duty_wr_idx), 16'(duty_wr_data)}, wr_q.pop_front());
        end
        if (hall_wr) begin
            wr_seen++;
            if (wr_q.size() == 0) unexpected("hall_wr", {8'd2, 8'(hall_wr_idx), 16'(hall_wr_data)});
            else check("hall_wr", {8'd2, 8'(hall_wr_idx), 16'(hall_wr_data)}, wr_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    function automatic int model_len(input logic [7:0] c);
        case (c)
            8'h80, 8'h93: return 2 * NM;
            8'h12, 8'h92: return NM;
            default:      return 0;
        endcase
    endfunction

    task automatic build_resp(input logic [7:0] c);
        for (int i = 0; i < 2 * NM; i++) exp_resp[i] = 8'h00;
        for (int m = 0; m < NM; m++) begin
            if (c == 8'h80) begin
                exp_resp[2*m]   = enc_counts[m*EW +: 8];
                exp_resp[2*m+1] = enc_counts[m*EW+8 +: 8];
            end else if (c == 8'h92) begin
                exp_resp[m] = hall_mem[m];
            end else if (c == 8'h93) begin
                exp_resp[2*m]   = duty_rb[m*DW +: 8];
                exp_resp[2*m+1] = {5'b0, duty_rb[m*DW+8 +: 3]};
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        spi.rx_data   = b;
        spi.rx_valid  = 1'b1;
        spi.frame_end = fe;
        tick(1);
        spi.rx_valid  = 1'b0;
        spi.frame_end = 1'b0;
        spi.rx_data   = 8'h00;
        tick(3);
    endtask

    task automatic start_frame();
        tx_q.push_back({m_en, 7'h00});
        spi.frame_start = 1'b1;
        tick(1);
        spi.frame_start = 1'b0;
        tick(2);
    endtask

    task automatic end_frame();
        spi.frame_end = 1'b1;
        tick(1);
        spi.frame_end = 1'b0;
        tick(2);
    endtask

    // Sends the command plus n data bytes, pushing the model's predicted tx bytes and writes.
    task automatic send_cmd_and_data(input logic [7:0] c, input int n, input logic [191:0] d);
        int         len;
        logic [7:0] b;
        logic [7:0] prev;
        build_resp(c);
        len  = model_len(c);
        prev = 8'h00;
        tx_q.push_back(len > 0 ? exp_resp[0] : 8'h00);
        send_byte(c, 1'b0);
        if (c[6:0] == 7'h30) m_en = c[7];
        for (int j = 0; j < n; j++) begin
            b = d[8*j +: 8];
            if (j < len && c == 8'h80 && j[0]) wr_q.push_back({8'd1, 8'(j / 2), 16'({b[2:0], prev})});
            if (j < len && c == 8'h12) begin
                wr_q.push_back({8'd2, 8'(j), 16'(b)});
                hall_mem[j] = b;
            end
            tx_q.push_back(j + 1 < len ? exp_resp[j+1] : 8'h00);
            send_byte(b, 1'b0);
            prev = b;
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_tx_pending"}, tx_q.size(), 0);
        check({tag, "_wr_pending"}, wr_q.size(), 0);
        tx_q.delete();
        wr_q.delete();
    endtask

    initial begin
        int wr0;
        rst             = 1'b1;
        spi.frame_start = 1'b0;
        spi.frame_end   = 1'b0;
        spi.rx_valid    = 1'b0;
        spi.rx_data     = 8'h00;
        m_en            = 1'b0;
        for (int m = 0; m < NM; m++) begin
            hall_mem[m] = 8'h00;
            enc_counts[m*EW +: EW] = 16'h1234 + 16'(m) * 16'h1111;
            duty_rb[m*DW +: DW]    = 11'h5A3 - 11'(m) * 11'h0F7;
        end

        tbl[0] = '{8'h80, 10, {8'h02, 8'hF6, 8'h01, 8'h4B, 8'h01, 8'hE3, 8'h01, 8'hBD, 8'h03, 8'hEC}, 1'b1, 1'b0, 5};
        tbl[1] = '{8'h12, 5,  {8'h03, 8'h05, 8'h02, 8'h0A, 8'h08}, 1'b1, 1'b0, 5};
        tbl[2] = '{8'h92, 5,  {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b1, 1'b0, 0};
        tbl[3] = '{8'hB0, 0,  192'h0, 1'b1, 1'b1, 0};
        tbl[4] = '{8'h93, 22, {24{8'hA5}}, 1'b1, 1'b1, 0};
        tbl[5] = '{8'h30, 2,  {8'h99, 8'h77}, 1'b1, 1'b0, 0};
        tbl[6] = '{8'h55, 4,  {8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 1'b0, 0};
        tbl[7] = '{8'h80, 1,  {8'h10}, 1'b1, 1'b0, 0};
        tbl[8] = '{8'hB0, 0,  192'h0, 1'b1, 1'b1, 0};

        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_tx_data", {24'h0, spi.tx_data}, 32'h00);
        check("rst_tx_load", {31'h0, spi.tx_load}, 32'h0);
        check("rst_duty_wr", {31'h0, duty_wr}, 32'h0);
        check("rst_hall_wr", {31'h0, hall_wr}, 32'h0);
        check("rst_motors_en", {31'h0, motors_en}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);

        for (int v = 0; v < 9; v++) begin
            wr0 = wr_seen;
            start_frame();
            check("busy_in_frame", {31'h0, busy}, 32'h1);
            send_cmd_and_data(tbl[v].cmd, tbl[v].n, tbl[v].d);
            if (tbl[v].fe) end_frame();
            check("busy_after_end", {31'h0, busy}, 32'h0);
            check("motors_en", {31'h0, motors_en}, {31'h0, tbl[v].exp_en});
            check("write_count", wr_seen - wr0, tbl[v].exp_wr);
            check_drained("frame");
        end

        // frame_start mid-frame aborts a half-written duty pair
        wr0 = wr_seen;
        start_frame();
        send_cmd_and_data(8'h80, 3, {8'h44, 8'h05, 8'h21});
        start_frame();
        check("abort_busy", {31'h0, busy}, 32'h1);
        send_cmd_and_data(8'hB0, 1, {8'h07});
        end_frame();
        check("abort_write_count", wr_seen - wr0, 1);
        check("abort_motors_en", {31'h0, motors_en}, 32'h1);
        check_drained("abort");

        // byte and frame_end in the same cycle: byte still lands, then idle
        wr0 = wr_seen;
        start_frame();
        send_cmd_and_data(8'h12, 0, 192'h0);
        wr_q.push_back({8'd2, 8'd0, 16'h003C});
        hall_mem[0] = 8'h3C;
        send_byte(8'h3C, 1'b1);
        check("fe_same_cycle_busy", {31'h0, busy}, 32'h0);
        check("fe_same_cycle_writes", wr_seen - wr0, 1);
        check_drained("fe_same_cycle");

        // reset after the third byte of a duty frame
        start_frame();
        send_cmd_and_data(8'h80, 2, {8'h02, 8'h11});
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_en = 1'b0;
        check("midrst_tx_data", {24'h0, spi.tx_data}, 32'h00);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_motors_en", {31'h0, motors_en}, 32'h0);
        check("midrst_duty_idx", {29'h0, duty_wr_idx}, 32'h0);
        check("midrst_duty_data", 32'(duty_wr_data), 32'h0);
        check("midrst_hall_data", 32'(hall_wr_data), 32'h0);
        wr0 = wr_seen;
        send_byte(8'h33, 1'b0);
        send_byte(8'h01, 1'b0);
        end_frame();
        check("midrst_write_count", wr_seen - wr0, 0);
        check_drained("midrst");

        // first frame after the reset still works
        start_frame();
        send_cmd_and_data(8'h93, 2, {8'h00, 8'h00});
        end_frame();
        check_drained("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/robocup_cmd_decoder.md
ROBOCUP_CMD_DECODER -- requirements
Module: robocup_cmd_decoder

Interface
REQ-001 Parameters: NUM_MOTORS, default 5, motor channel count; ENC_WIDTH, default 16, encoder count width; DUTY_WIDTH, default 11, duty cycle width; HALL_WIDTH, default 8, hall count width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 sysclk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 frame_start  in  1  one-cycle pulse, SPI slave chip-select asserted.
REQ-006 frame_end  in  1  one-cycle pulse, SPI slave chip-select released.
REQ-007 rx_valid  in  1  one-cycle pulse, complete byte received from SPI slave.
REQ-008 rx_data  in  8  received byte, valid with rx_valid.
REQ-009 tx_data  out  8  byte the SPI slave shifts out during the next byte.
REQ-010 tx_load  out  1  one-cycle pulse, tx_data updated.
REQ-011 enc_counts  in  NUM_MOTORS*ENC_WIDTH  live encoder counts, motor 0 in LSBs.
REQ-012 hall_counts  in  NUM_MOTORS*HALL_WIDTH  live hall counts.
REQ-013 duty_rb  in  NUM_MOTORS*DUTY_WIDTH  current duty cycles.
REQ-014 duty_wr / duty_wr_idx / duty_wr_data  out  1 / 3 / DUTY_WIDTH  duty write strobe, motor index, value.
REQ-015 hall_wr / hall_wr_idx / hall_wr_data  out  1 / 3 / HALL_WIDTH  hall count preset strobe, index, value.
REQ-016 motors_en  out  1  global motor enable.
REQ-017 busy  out  1  high while a frame is in progress.

Function
REQ-018 First byte after frame_start is the command: cmd[7] = flag F, cmd[6:0] = opcode.
REQ-019 Opcode 0x00, F=1 (0x80): 2*NUM_MOTORS data bytes, low byte then high byte per motor, motor 0 first; duty = {high[DUTY_WIDTH-9:0], low}.
REQ-020 On each high byte of 0x80, duty_wr pulses for 1 cycle, 1 cycle after its rx_valid, with that motor's index and value.
REQ-021 On command 0x80, all encoder counts snapshot in the cycle after command rx_valid; response bytes are snapshot low/high bytes per motor, motor 0 first.
REQ-022 Opcode 0x12, F=1 (0x92): response is one hall count byte per motor, snapshot at command decode.
REQ-023 Opcode 0x12, F=0 (0x12): each data byte n pulses hall_wr with idx n, data rx_data, 1 cycle after rx_valid.
REQ-024 Opcode 0x13, F=1 (0x93): response is duty_rb low/high byte per motor (high zero-extended), snapshot at decode.
REQ-025 Opcode 0x30: motors_en <= F, 1 cycle after command rx_valid; no data bytes.
REQ-026 Any other command: no side effects, all response bytes 0x00.
REQ-027 On frame_start: tx_data <= {motors_en, 7'h00}, tx_load pulses (status byte shifted during command byte).
REQ-028 After each rx_valid, next response byte on tx_data with tx_load within 2 cycles; 0x00 beyond the defined payload.
REQ-029 State machine: IDLE -> CMD on frame_start; CMD -> DATA on command rx_valid; DATA -> DROP after last defined byte; any state -> IDLE on frame_end.
REQ-030 Bytes in DROP or IDLE cause no writes.
REQ-031 frame_end after a duty low byte without its high byte: that duty write is discarded.
REQ-032 frame_start while busy: current frame aborted, new frame started, no further writes from the old frame.
REQ-033 frame_end and rx_valid same cycle: byte processed first, then IDLE.
REQ-034 busy = 1 in CMD, DATA, DROP.

Reset
REQ-035 rst: state IDLE, tx_data 0x00, tx_load 0, duty_wr 0, hall_wr 0, indices/data 0, motors_en 0, busy 0, snapshots 0.
REQ-036 rst mid-frame: frame abandoned; no further writes until a new frame_start.

Verification
REQ-037 Frame 0x80, 0xEC,0x03, 0xBD,0x01, 0xE3,0x01, 0x4B,0x01, 0xF6,0x02 -> duty_wr idx0..4 values 0x3EC,0x1BD,0x1E3,0x14B,0x2F6; tx bytes = encoder snapshot.
REQ-038 Frame 0x12, 0x08,0x0A,0x02,0x05,0x03 then 0x92 + 5 bytes with hall_counts reflecting writes -> hall_wr idx0..4, readback bytes 0x08,0x0A,0x02,0x05,0x03.
REQ-039 Frame 0x30 -> motors_en 0; frame 0xB0 -> motors_en 1; next status byte 0x80.
REQ-040 Frame 0x80, 0x10 then frame_end -> no duty_wr; 12 extra bytes after 0x93 payload -> tx 0x00, no writes.
REQ-041 rst asserted after third byte of 0x80 frame -> all outputs at reset values, remaining bytes ignored until next frame_start.
